// File: rtl/ps2_key_event_scheduler.sv
// ============================================================================
// ps2_key_event_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   Brings PS/2 receiver key events into the clk_100mhz domain. Suppresses
//   typematic repeats of keys that are already held (optional). Queues
//   {ext,rel,code} entries in a FIFO and presents them to a single consumer
//   over a valid/ready handshake.
//
// Ports:
//   clk_100mhz    in   system clock
//   rst           in   asynchronous, active-high reset
//   key_event     in   [7:0] scan code, [8] F0 break, [9] E0 extended,
//                      [10] valid (asynchronous; [9:0] stable while [10]=1)
//   evt_ready     in   consumer accepts the head entry when evt_valid=1
//   clr_overflow  in   clears the overflow sticky bit
//   evt_valid     out  FIFO non-empty
//   evt_code      out  head scan code
//   evt_ext       out  head entry carried the E0 prefix
//   evt_release   out  head entry carried the F0 prefix (break)
//   fifo_count    out  number of entries held
//   overflow      out  sticky: an event was dropped because the FIFO was full
//   dbg_state     out  current FSM state (0 IDLE, 1 CAPTURE, 2 FILTER, 3 PUSH)
//
// Handshake: an entry transfers on every rising clock edge where
// evt_valid && evt_ready. The head outputs hold steady while
// evt_valid && !evt_ready. evt_ready has no effect while evt_valid=0.
// ============================================================================
module ps2_key_event_scheduler #(
   parameter int FIFO_DEPTH   = 8,
   parameter bit SUPPRESS_REP = 1'b1
) (
   input  logic                          clk_100mhz,
   input  logic                          rst,
   input  logic [10:0]                   key_event,
   input  logic                          evt_ready,
   input  logic                          clr_overflow,
   output logic                          evt_valid,
   output logic [7:0]                    evt_code,
   output logic                          evt_ext,
   output logic                          evt_release,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [1:0]                    dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_FILTER  = 2'd2,
      S_PUSH    = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_sync1, r_sync2, r_sync3;
   logic [9:0]    r_evt;               // {ext, rel, code}
   logic [511:0]  r_held;              // indexed by {ext, code}
   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic          w_edge;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [8:0]    w_idx;
   logic [9:0]    w_head;

   // r_sync3 holds the previous synchronized value, so a new event is a
   // one-cycle pulse on the rising edge of r_sync2.
   assign w_edge = r_sync2 & ~r_sync3;
   assign w_idx  = {r_evt[9], r_evt[7:0]};
   assign w_pop  = (r_count != '0) && evt_ready;
   // A full FIFO still accepts the push when the consumer pops in the same cycle.
   assign w_push = (r_state == S_PUSH) && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
   assign w_drop = (r_state == S_PUSH) && !w_push;

   // ---------------------------------------------------------------------
   // Synchronizer for the valid strobe. The data bits are stable long before
   // the strobe is seen, so they are sampled directly when the edge is seen.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= key_event[10];
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // ---------------------------------------------------------------------
   // Capture / filter FSM. An edge outside IDLE is ignored.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_evt   <= '0;
         r_held  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  r_evt   <= key_event[9:0];
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // A prefix byte delivered as a code is a malformed frame.
               if (r_evt[7:0] == 8'hF0 || r_evt[7:0] == 8'hE0)
                  r_state <= S_IDLE;
               else
                  r_state <= S_FILTER;
            end
            S_FILTER: begin
               if (r_evt[8]) begin
                  r_held[w_idx] <= 1'b0;
                  r_state       <= S_PUSH;
               end else if (SUPPRESS_REP && r_held[w_idx]) begin
                  r_state <= S_IDLE;
               end else begin
                  r_held[w_idx] <= 1'b1;
                  r_state       <= S_PUSH;
               end
            end
            S_PUSH: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FIFO pointers, occupancy and overflow flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_overflow)
            r_overflow <= 1'b0;
      end
   end

   // Storage has no reset. The outputs below are gated, so stale contents never appear.
   always_ff @(posedge clk_100mhz) begin
      if (w_push) r_mem[r_wr_ptr] <= r_evt;
   end

   assign w_head      = (r_count != '0) ? r_mem[r_rd_ptr] : 10'd0;
   assign evt_valid   = (r_count != '0);
   assign evt_code    = w_head[7:0];
   assign evt_release = w_head[8];
   assign evt_ext     = w_head[9];
   assign fifo_count  = r_count;
   assign overflow    = r_overflow;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_key_event_scheduler.sv
module tb_ps2_key_event_scheduler;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic [10:0] key_event;
  logic        evt_ready;
  logic        clr_overflow;

  logic        evt_valid, evt_ext, evt_release, overflow;
  logic [7:0]  evt_code;
  logic [3:0]  fifo_count;
  logic [1:0]  dbg_state;

  logic        nr_ready;
  logic        nr_valid, nr_ext, nr_release, nr_overflow;
  logic [7:0]  nr_code;
  logic [3:0]  nr_count;
  logic [1:0]  nr_state;

  logic [9:0]  exp_q[$];
  logic [9:0]  exp_nr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  int          n_pop_nr = 0;
  int          lat;
  int          p0, q0;

  // clock / reset
  always #5 clk_100mhz = ~clk_100mhz;

  ps2_key_event_scheduler #(.FIFO_DEPTH(8), .SUPPRESS_REP(1'b1)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .key_event(key_event),
    .evt_ready(evt_ready), .clr_overflow(clr_overflow),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_release(evt_release), .fifo_count(fifo_count),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  ps2_key_event_scheduler #(.FIFO_DEPTH(8), .SUPPRESS_REP(1'b0)) dut_nr (
    .clk_100mhz(clk_100mhz), .rst(rst), .key_event(key_event),
    .evt_ready(nr_ready), .clr_overflow(clr_overflow),
    .evt_valid(nr_valid), .evt_code(nr_code), .evt_ext(nr_ext),
    .evt_release(nr_release), .fifo_count(nr_count),
    .overflow(nr_overflow), .dbg_state(nr_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: sample 1 time unit after the falling edge
  always @(negedge clk_100mhz) begin
    #1;
    if (!rst && evt_valid && evt_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL main_unexpected: got %0h expected none", {evt_ext, evt_release, evt_code});
      end else
        check("main_entry", {22'd0, evt_ext, evt_release, evt_code}, {22'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk_100mhz) begin
    #1;
    if (!rst && nr_valid && nr_ready) begin
      n_pop_nr++;
      if (exp_nr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL nr_unexpected: got %0h expected none", {nr_ext, nr_release, nr_code});
      end else
        check("nr_entry", {22'd0, nr_ext, nr_release, nr_code}, {22'd0, exp_nr_q.pop_front()});
    end
  end

  // driver: one receiver event, 6 cycles strobe high, 10 cycles low.
  // rdy_k pulses evt_ready for one cycle at that step (-10 = no pulse).
  // lat records the first step at which evt_valid rises.
  task automatic send(input logic ext, input logic rel, input logic [7:0] code, input int rdy_k);
    logic v0;
    @(negedge clk_100mhz);
    key_event = {1'b1, ext, rel, code};
    v0 = evt_valid;
    lat = -1;
    // The repeat-forwarding instance is never full, so it takes every well-formed frame.
    if (!(code == 8'hF0 || code == 8'hE0)) exp_nr_q.push_back({ext, rel, code});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_100mhz);
      if (k == 6) key_event[10] = 1'b0;
      if (k == rdy_k) evt_ready = 1'b1;
      if (k == rdy_k + 1) evt_ready = 1'b0;
      #1;
      if (lat < 0 && evt_valid && !v0) lat = k;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100mhz);
    #1;
  endtask

  initial begin
    logic [7:0] c;
    rst = 1'b1; key_event = '0; evt_ready = 1'b0; clr_overflow = 1'b0; nr_ready = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    idle(1);
    check("rst_valid", evt_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_head", {evt_ext, evt_release, evt_code}, 0);
    check("rst_state", dbg_state, 0);

    // 1: single make, latency, then break the same key
    evt_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    send(1'b0, 1'b0, 8'h1C, -10);
    check("t1_latency", lat, 6);          // 2 sync + 4 cycles after synced edge
    check("t1_count", fifo_count, 0);
    exp_q.push_back({2'b01, 8'h1C});
    send(1'b0, 1'b1, 8'h1C, -10);

    // 2: typematic repeats are suppressed only in the main instance
    p0 = n_pop; q0 = n_pop_nr;
    exp_q.push_back({2'b00, 8'h1C});
    send(1'b0, 1'b0, 8'h1C, -10);
    send(1'b0, 1'b0, 8'h1C, -10);
    send(1'b0, 1'b0, 8'h1C, -10);
    exp_q.push_back({2'b01, 8'h1C});
    send(1'b0, 1'b1, 8'h1C, -10);
    check("t2_main_entries", n_pop - p0, 2);
    check("t2_nr_entries", n_pop_nr - q0, 4);

    // 3: extended make/break, then plain code of the same byte, then a malformed frame
    exp_q.push_back({2'b10, 8'h75});
    send(1'b1, 1'b0, 8'h75, -10);
    exp_q.push_back({2'b11, 8'h75});
    send(1'b1, 1'b1, 8'h75, -10);
    exp_q.push_back({2'b00, 8'h75});
    send(1'b0, 1'b0, 8'h75, -10);
    exp_q.push_back({2'b01, 8'h75});
    send(1'b0, 1'b1, 8'h75, -10);
    p0 = n_pop;
    send(1'b0, 1'b0, 8'hF0, -10);
    check("t3_malformed_dropped", n_pop - p0, 0);
    check("t3_malformed_count", fifo_count, 0);

    // 4: overflow with the consumer stalled
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c = 8'h10 + 8'(i);
      if (i < 8) exp_q.push_back({2'b00, c});
      send(1'b0, 1'b0, c, -10);
    end
    check("t4_count_full", fifo_count, 8);
    check("t4_overflow_set", overflow, 1);
    check("t4_head_stable", evt_code, 8'h10);
    @(negedge clk_100mhz); clr_overflow = 1'b1;
    @(negedge clk_100mhz); clr_overflow = 1'b0;
    #1;
    check("t4_overflow_clr", overflow, 0);
    evt_ready = 1'b1;
    idle(12);
    check("t4_drained", fifo_count, 0);

    // 5: full FIFO, pop in the same cycle as PUSH
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = 8'h20 + 8'(i);
      exp_q.push_back({2'b00, c});
      send(1'b0, 1'b0, c, -10);
    end
    check("t5_count_full", fifo_count, 8);
    exp_q.push_back({2'b00, 8'h28});
    send(1'b0, 1'b0, 8'h28, 5);
    check("t5_count_kept", fifo_count, 8);
    check("t5_no_overflow", overflow, 0);
    evt_ready = 1'b1;
    idle(12);
    check("t5_drained", fifo_count, 0);

    // 6: reset with entries queued and a key held
    evt_ready = 1'b0;
    send(1'b0, 1'b0, 8'h30, -10);
    send(1'b0, 1'b0, 8'h31, -10);
    send(1'b0, 1'b0, 8'h32, -10);
    check("t6_count_before", fifo_count, 3);
    @(negedge clk_100mhz); rst = 1'b1;
    idle(2);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_valid", evt_valid, 0);
    @(negedge clk_100mhz); rst = 1'b0;
    evt_ready = 1'b1;
    p0 = n_pop;
    exp_q.push_back({2'b00, 8'h30});
    send(1'b0, 1'b0, 8'h30, -10);
    check("t6_make_after_rst", n_pop - p0, 1);

    idle(20);
    check("main_queue_empty", exp_q.size(), 0);
    check("nr_queue_empty", exp_nr_q.size(), 0);
    check("nr_no_overflow", nr_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
